alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mul_seq.sv | 89 ++++++++
 rtl/alu_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the sequential ALU: the gin operation codes and
// the controller state type. Imported by alu_seq and alu_mul_seq.
package alu_pkg;

    // gin operation select encodings
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// Iterative unsigned shift-add multiplier, one partial product per cycle,
// WIDTH cycles per operation. Only the low WIDTH bits are kept.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset; aborts any operation
//   load     capture a/b, clear the accumulator, start iterating
//   a, b     multiplicand / multiplier
//   busy     iteration in progress
//   fin      high during the last iteration cycle
//   product  accumulator value including the current step; equals the
//            final product while fin is high
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] product
);

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        // Bit 0 of the right-shifting multiplier gates the left-shifting
        // multiplicand into the accumulator.
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;

        if (load) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    // Product is taken from the step in progress so the controller can
    // register the result on the final iteration edge without an extra cycle.
    assign busy    = busy_q;
    assign fin     = busy_q && (cnt_q == LAST);
    assign product = acc_step;

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Sequential ALU: single-cycle logic/arith/shift ops and a WIDTH-cycle
// iterative multiply, with registered result and flags.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           request strobe; gin, a, b, shamt sampled with it
//   gin             operation select (see alu_pkg)
//   a, b, shamt     operands and shift amount
//   sum             registered result
//   zout            registered zero flag of sum
//   ovf             registered signed overflow (ADD/SUB only)
//   busy            multiply in flight
//   done            one-cycle pulse when sum/zout/ovf are updated
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       gin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] sum,
    output logic             zout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             zout_q, zout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] add_r;
    logic [WIDTH-1:0] sub_r;

    logic             mul_load;
    logic             mul_busy;
    logic             mul_fin;
    logic [WIDTH-1:0] mul_product;

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .fin     (mul_fin),
        .product (mul_product)
    );

    // Single-cycle datapath
    always_comb begin
        add_r   = a + b;
        sub_r   = a + ~b + WIDTH'(1);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (gin)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: begin
                alu_res = add_r;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (add_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_r;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (sub_r[WIDTH-1] != a[WIDTH-1]);
            end
            // Raw sign of a-b, deliberately not overflow-corrected
            OP_SLT: alu_res[0] = sub_r[WIDTH-1];
            OP_SRL: alu_res = b >> shamt;
            OP_SLL: alu_res = b << shamt;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sum_q   <= '0;
            zout_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            zout_q  <= zout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        zout_d   = zout_q;
        ovf_d    = ovf_q;
        mul_load = 1'b0;

        case (state_q)
            // DONE accepts a new request exactly like IDLE, which gives
            // back-to-back single-cycle operations.
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (gin == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = MUL;
                    end else begin
                        sum_d   = alu_res;
                        zout_d  = (alu_res == '0);
                        ovf_d   = alu_ovf;
                        state_d = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_fin) begin
                    sum_d   = mul_product;
                    zout_d  = (mul_product == '0);
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sum  = sum_q;
    assign zout = zout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == MUL);
    assign done = (state_q == DONE);

endmodule
